// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: sequential PC generation, single-outstanding imem
// requests, PC-tagged prefetch FIFO with valid/ready delivery and redirect flush.
module instr_fetch_unit #(
  parameter int          DEPTH   = 4,
  parameter int unsigned PC_STEP = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [31:0]              startPC,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0]   STEP = 32'(PC_STEP);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_e;

  state_e          state_q;
  logic [31:0]     fetch_pc_q;
  logic            req_q;
  logic [31:0]     addr_q;
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     fifo_instr_q [DEPTH];
  logic [31:0]     fifo_pc_q    [DEPTH];
  logic [31:0]     hold_instr_q, hold_pc_q;
  logic            push, pop, not_empty;

  assign not_empty   = (count_q != '0);
  assign instr_valid = not_empty && !redirect;
  assign pop         = instr_valid && instr_ready;
  assign push        = (state_q == REQ) && imem_ack && !redirect;

  // Head is shown while occupied; otherwise the last shown values are held.
  assign instr      = not_empty ? fifo_instr_q[rd_ptr_q] : hold_instr_q;
  assign instr_pc   = not_empty ? fifo_pc_q[rd_ptr_q]    : hold_pc_q;
  assign fifo_count = count_q;
  assign imem_req   = req_q;
  assign imem_addr  = addr_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
      fifo_pc_q[wr_ptr_q]    <= fetch_pc_q;
    end
  end

  // addr_q tracks fetch_pc_q except in DISCARD, where it keeps the killed address.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      fetch_pc_q   <= startPC;
      req_q        <= 1'b0;
      addr_q       <= startPC;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      hold_instr_q <= instr;
      hold_pc_q    <= instr_pc;
      if (redirect) begin
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        count_q    <= '0;
        fetch_pc_q <= redirect_pc;
        if (state_q == IDLE || imem_ack) begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          addr_q  <= redirect_pc;
        end else begin
          state_q <= DISCARD;
          req_q   <= 1'b1;
        end
      end else begin
        count_q <= count_d;
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        case (state_q)
          IDLE: begin
            if (count_q < FULL) begin
              state_q <= REQ;
              req_q   <= 1'b1;
            end
          end
          REQ: begin
            if (imem_ack) begin
              fetch_pc_q <= fetch_pc_q + STEP;
              addr_q     <= fetch_pc_q + STEP;
              if (count_d == FULL) begin
                state_q <= IDLE;
                req_q   <= 1'b0;
              end
            end
          end
          DISCARD: begin
            if (imem_ack) begin
              state_q <= IDLE;
              req_q   <= 1'b0;
              addr_q  <= fetch_pc_q;
            end
          end
          default: begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= fetch_pc_q;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed scenarios push expected
// {pc,data} pairs; a negedge monitor pops and compares on every delivery.
module tb_instr_fetch_unit;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] startPC = 32'h100;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [2:0]  fifo_count;

  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        force_ack = 1'b0;
  int          mem_lat = 0;
  int          wcnt = 0;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  assign imem_ack   = mem_ack | force_ack;
  assign imem_rdata = force_ack ? 32'hDEADBEEF : mem_rdata;

  instr_fetch_unit #(.DEPTH(4), .PC_STEP(4)) dut (
    .CLK(CLK), .RESET(RESET), .startPC(startPC),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .fifo_count(fifo_count)
  );

  always #5 CLK = ~CLK;

  // Memory model: acks after mem_lat idle request cycles; data = {addr[15:0], C0DE}.
  always @(posedge CLK) begin
    #2;
    if (!imem_req) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end else if (wcnt >= mem_lat) begin
      mem_ack   = 1'b1;
      mem_rdata = {imem_addr[15:0], 16'hC0DE};
      wcnt      = 0;
    end else begin
      mem_ack = 1'b0;
      wcnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RESET && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected delivery: got pc %h data %h expected none", instr_pc, instr);
      end else begin
        mon_e = sb.pop_front();
        chk("deliver pc", instr_pc, mon_e.pc);
        chk("deliver data", instr, mon_e.data);
      end
    end
  end

  task automatic exp_push(input logic [31:0] pc, input logic [31:0] data);
    exp_t e;
    e.pc   = pc;
    e.data = data;
    sb.push_back(e);
  endtask

  // Called in the #1-after-edge phase; returns #1 after the last reset edge.
  task automatic do_reset(input logic [31:0] pc);
    RESET       = 1'b1;
    startPC     = pc;
    redirect    = 1'b0;
    instr_ready = 1'b0;
    force_ack   = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("rst imem_req", imem_req, 0);
    chk("rst imem_addr", imem_addr, pc);
    chk("rst instr_valid", instr_valid, 0);
    chk("rst instr", instr, 0);
    chk("rst instr_pc", instr_pc, 0);
    chk("rst fifo_count", fifo_count, 0);
    @(posedge CLK);
    #1 RESET = 1'b0;
    sb.delete();
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(posedge CLK);
      n++;
    end
    #1 instr_ready = 1'b0;
    chk("drain remaining", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // 1: zero-wait streaming
    mem_lat = 0;
    #1 do_reset(32'h100);
    instr_ready = 1'b1;
    exp_push(32'h100, 32'h0100C0DE); exp_push(32'h104, 32'h0104C0DE);
    exp_push(32'h108, 32'h0108C0DE); exp_push(32'h10C, 32'h010CC0DE);
    exp_push(32'h110, 32'h0110C0DE); exp_push(32'h114, 32'h0114C0DE);
    exp_push(32'h118, 32'h0118C0DE); exp_push(32'h11C, 32'h011CC0DE);
    @(negedge CLK);
    chk("t1 req after release", imem_req, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("t1 req", imem_req, 1);
      chk("t1 addr", imem_addr, 32'h100 + 32'(4 * k));
      chk("t1 count<=1", {31'b0, fifo_count <= 3'd1}, 1);
    end
    drain();

    // 2: consumer stalled, FIFO fills, single pop reopens fetch
    do_reset(32'h100);
    repeat (8) @(posedge CLK);
    @(negedge CLK);
    chk("t2 full count", fifo_count, 4);
    chk("t2 full req", imem_req, 0);
    chk("t2 head pc", instr_pc, 32'h100);
    @(posedge CLK);
    #1 exp_push(32'h100, 32'h0100C0DE);
    instr_ready = 1'b1;
    @(posedge CLK);
    #1 instr_ready = 1'b0;
    @(negedge CLK);
    chk("t2 count after pop", fifo_count, 3);
    chk("t2 req after pop", imem_req, 0);
    @(negedge CLK);
    chk("t2 refetch req", imem_req, 1);
    chk("t2 refetch addr", imem_addr, 32'h110);
    @(negedge CLK);
    chk("t2 refill count", fifo_count, 4);
    chk("t2 refill req", imem_req, 0);
    chk("t2 new head pc", instr_pc, 32'h104);
    chk("t2 sb empty", sb.size(), 0);
    @(posedge CLK);
    #1;

    // 3: redirect during a slow request -> DISCARD
    mem_lat = 3;
    do_reset(32'h100);
    instr_ready = 1'b1;
    exp_push(32'h100, 32'h0100C0DE); exp_push(32'h104, 32'h0104C0DE);
    exp_push(32'h400, 32'h0400C0DE); exp_push(32'h404, 32'h0404C0DE);
    n = 0;
    while (!(imem_req && imem_addr == 32'h108) && n < 40) begin
      @(posedge CLK);
      #1 n++;
    end
    chk("t3 req 0x108 seen", imem_addr, 32'h108);
    @(posedge CLK);
    #1 redirect = 1'b1;
    redirect_pc = 32'h400;
    @(negedge CLK);
    chk("t3 valid in redirect", instr_valid, 0);
    @(posedge CLK);
    #1 redirect = 1'b0;
    @(negedge CLK);
    chk("t3 count after redirect", fifo_count, 0);
    chk("t3 discard req", imem_req, 1);
    chk("t3 discard addr", imem_addr, 32'h108);
    n = 0;
    while ((!imem_req || imem_addr == 32'h108) && n < 40) begin
      @(posedge CLK);
      #1 n++;
    end
    chk("t3 next req addr", imem_addr, 32'h400);
    drain();

    // 4: redirect coincident with ack, two entries buffered
    mem_lat = 0;
    do_reset(32'h100);
    exp_push(32'h200, 32'h0200C0DE); exp_push(32'h204, 32'h0204C0DE);
    repeat (3) @(posedge CLK);
    #1 redirect = 1'b1;
    redirect_pc = 32'h200;
    instr_ready = 1'b1;
    @(negedge CLK);
    chk("t4 ack present", imem_ack, 1);
    chk("t4 count before", fifo_count, 2);
    chk("t4 valid forced low", instr_valid, 0);
    @(posedge CLK);
    #1 redirect = 1'b0;
    @(negedge CLK);
    chk("t4 count flushed", fifo_count, 0);
    chk("t4 idle req", imem_req, 0);
    chk("t4 idle addr", imem_addr, 32'h200);
    @(negedge CLK);
    chk("t4 refetch req", imem_req, 1);
    chk("t4 refetch addr", imem_addr, 32'h200);
    drain();

    // 5: PC wrap
    do_reset(32'hFFFFFFF8);
    instr_ready = 1'b1;
    exp_push(32'hFFFFFFF8, 32'hFFF8C0DE); exp_push(32'hFFFFFFFC, 32'hFFFCC0DE);
    exp_push(32'h00000000, 32'h0000C0DE); exp_push(32'h00000004, 32'h0004C0DE);
    drain();

    // 6: reset mid-request, stale ack right after release
    mem_lat = 5;
    do_reset(32'h100);
    n = 0;
    while (!imem_req && n < 20) begin
      @(posedge CLK);
      #1 n++;
    end
    chk("t6 req pending", imem_req, 1);
    do_reset(32'h300);
    exp_push(32'h300, 32'h0300C0DE); exp_push(32'h304, 32'h0304C0DE);
    force_ack = 1'b1;
    @(posedge CLK);
    #1 force_ack = 1'b0;
    instr_ready = 1'b1;
    @(negedge CLK);
    chk("t6 req after stale ack", imem_req, 1);
    chk("t6 addr after stale ack", imem_addr, 32'h300);
    chk("t6 count after stale ack", fifo_count, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
